// File: rtl/dw03_updn_ctr_pkg.sv
// dw03_updn_ctr_pkg: shared width default and count-direction encoding for the up/down counter.
package dw03_updn_ctr_pkg;

    localparam int DW03_UPDN_CTR_WIDTH_DEFAULT = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/dw03_updn_ctr_tc.sv
// dw03_updn_ctr_tc: terminal-count decoder, all-ones when counting up, zero when counting down.
module dw03_updn_ctr_tc
    import dw03_updn_ctr_pkg::*;
#(
    parameter int width = DW03_UPDN_CTR_WIDTH_DEFAULT
) (
    input  logic [width-1:0] count,
    input  logic             up_dn,
    output logic             tercnt
);

    assign tercnt = (dir_e'(up_dn) == DIR_UP) ? &count : ~|count;

endmodule

// File: rtl/dw03_updn_ctr.sv
// dw03_updn_ctr: up/down counter with active-low load, count enable and terminal-count flag.
// Define DW03_UPDN_CTR_TERCNT_REG_EN to register tercnt (decoded from next count and current up_dn).
module dw03_updn_ctr
    import dw03_updn_ctr_pkg::*;
#(
    parameter int width = DW03_UPDN_CTR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] data,
    input  logic             up_dn,
    input  logic             load,
    input  logic             cen,
    output logic [width-1:0] count,
    output logic             tercnt
);

    logic [width-1:0] count_d;
    logic [width-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (!load)
            count_d = data;
        else if (cen)
            count_d = (dir_e'(up_dn) == DIR_UP) ? count_q + width'(1) : count_q - width'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

`ifdef DW03_UPDN_CTR_TERCNT_REG_EN
    logic tercnt_d;
    logic tercnt_q;

    dw03_updn_ctr_tc #(.width(width)) u_tc (
        .count  (count_d),
        .up_dn  (up_dn),
        .tercnt (tercnt_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tercnt_q <= 1'b0;
        else
            tercnt_q <= tercnt_d;
    end

    assign tercnt = tercnt_q;
`else
    dw03_updn_ctr_tc #(.width(width)) u_tc (
        .count  (count_q),
        .up_dn  (up_dn),
        .tercnt (tercnt)
    );
`endif

endmodule

// File: tb/tb_dw03_updn_ctr.sv
// tb_dw03_updn_ctr: vector table, corner sequences and randomized run against a modular-arithmetic model.
module tb_dw03_updn_ctr;
    import dw03_updn_ctr_pkg::*;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data;
    logic         up_dn;
    logic         load;
    logic         cen;
    logic [W-1:0] count;
    logic         tercnt;

    int total = 0;
    int bad   = 0;
    int m_cnt = 0;
    bit m_tcr = 1'b0;

    typedef struct {
        string    nm;
        bit       r;
        bit       l;
        bit       c;
        bit       u;
        logic [W-1:0] ec;
        bit       et;
    } vec_t;

    vec_t vecs[$];

    dw03_updn_ctr #(.width(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .up_dn  (up_dn),
        .load   (load),
        .cen    (cen),
        .count  (count),
        .tercnt (tercnt)
    );

    always #5 clk = ~clk;

    function automatic void add(string nm, bit r, bit l, bit c, bit u, int ec, bit et);
        vec_t v;
        v.nm = nm; v.r = r; v.l = l; v.c = c; v.u = u;
        v.ec = W'(ec); v.et = et;
        vecs.push_back(v);
    endfunction

    function automatic bit exp_tc();
`ifdef DW03_UPDN_CTR_TERCNT_REG_EN
        return m_tcr;
`else
        return up_dn ? (m_cnt == M - 1) : (m_cnt == 0);
`endif
    endfunction

    task automatic apply(bit r, bit l, bit c, bit u, logic [W-1:0] d);
        reset = r; load = l; cen = c; up_dn = u; data = d;
        if (!r) begin
            m_cnt = 0;
            m_tcr = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            if (!load)
                m_cnt = int'(data);
            else if (cen)
                m_cnt = up_dn ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
            m_tcr = up_dn ? (m_cnt == M - 1) : (m_cnt == 0);
        end
        #1;
    endtask

    task automatic chk(string nm, logic [W-1:0] ec, bit et);
        total += 2;
        if (count !== ec) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d at %0t", nm, count, ec, $time);
        end
        if (tercnt !== et) begin
            bad++;
            $display("FAIL %s tercnt: got %b want %b at %0t", nm, tercnt, et, $time);
        end
    endtask

    initial begin
        add("rst", 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) add("load", 1, 0, 0, 1, 7, 0);
        add("load_pri", 1, 0, 1, 1, 7, 0);
        for (int i = 0; i < 15; i++) add("up", 1, 1, 1, 1, (8 + i) % M, ((8 + i) % M) == M - 1);
        for (int i = 0; i < 15; i++) begin
            add("down", 1, 1, 1, 0, (5 - i + M) % M, ((5 - i + M) % M) == 0);
            if (i == 2)
                for (int k = 0; k < 3; k++) add("hold", 1, 1, 0, 0, 3, 0);
        end
        for (int i = 0; i < 15; i++) add("reload", 1, 0, 1, 1, 7, 0);

        apply(0, 1, 0, 1, 4'd7);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].r, vecs[i].l, vecs[i].c, vecs[i].u, 4'd7);
            tick();
            chk(vecs[i].nm, vecs[i].ec, vecs[i].et);
        end

        // Direction flip while parked at zero: combinational flag rises at once, registered one edge later.
        apply(0, 1, 0, 1, 4'd7);
        tick();
        apply(1, 1, 0, 1, 4'd7);
        chk("dc_up", 0, 0);
        up_dn = 1'b0;
        #1;
`ifdef DW03_UPDN_CTR_TERCNT_REG_EN
        chk("dc_dn_now", 0, 0);
`else
        chk("dc_dn_now", 0, 1);
`endif
        tick();
        chk("dc_dn_edge", 0, 1);

        apply(1, 1, 1, 1, 4'd7);
        tick(); tick(); tick();
        chk("pre_async", 3, 0);
        apply(0, 1, 1, 1, 4'd7);
        #1;
        chk("async_rst", 0, 0);
        tick();
        chk("rst_hold", 0, 0);

        apply(1, 0, 0, 1, 4'd15);
        tick();
        chk("load15", 15, 1);
        apply(1, 1, 1, 1, 4'd0);
        tick();
        chk("wrap_up", 0, 0);
        apply(1, 1, 1, 0, 4'd0);
        tick();
        chk("wrap_dn", 15, 0);

        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 19) != 0, $urandom_range(0, 7) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
            tick();
            chk("rand", W'(m_cnt), exp_tc());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
